// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, ALUOp, mux selects, ALU operations and small decode helpers.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALRWB   = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } alu_op_t;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Per-state control word; pc_write is the unqualified (pre-reset) value.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

    // funct3 010/011 have no branch meaning in RV32I.
    function automatic logic branch_legal(input logic [2:0] funct3);
        return (funct3 != 3'b010) && (funct3 != 3'b011);
    endfunction

    // res31 carries the SLT/SLTU result for the ordered compares.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic res31);
        case (funct3)
            3'b000:         return zero;
            3'b001:         return ~zero;
            3'b100, 3'b110: return res31;
            3'b101, 3'b111: return ~res31 | zero;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR/flag inputs plus mux selects and enables.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       res31;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal;

    // Controller side.
    modport master (
        input  op, funct3, funct7b5, zero, res31, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, RegWrite, instr_done, illegal
    );

    // Datapath side.
    modport slave (
        output op, funct3, funct7b5, zero, res31, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, RegWrite, instr_done, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode from ALUOp and the instruction function fields.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [3:0] alu_control
);

    // Select ALU operation: plain add, branch compare, or funct-decoded.
    // NOTE: default assigned first so every path drives alu_control (no latch).
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: alu_control = ALU_SLT;
                    3'b110, 3'b111: alu_control = ALU_SLTU;
                    default:        alu_control = ALU_SUB;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) uses funct7b5 to select subtract.
                    3'b000:  alu_control = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences a shared ALU and unified memory,
// stalling on the memory ready handshake.
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_controller_if.master bus
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;

    // State register; reset returns to FETCH at once, abandoning any access.
    // NOTE: non-blocking assignment for sequential state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (bus.mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_LUI:            w_next_state = S_LUI;
                    OP_AUIPC:          w_next_state = S_AUIPC;
                    default:           w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next_state = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_JALR:     w_next_state = S_JALRWB;
            S_JALRWB:   w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = branch_legal(bus.funct3) ? S_FETCH : S_TRAP;
            S_LUI:      w_next_state = S_ALUWB;
            S_AUIPC:    w_next_state = S_ALUWB;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Per-state control word; unlisted fields stay 0.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALU;
                w_ctrl.ir_write   = bus.mem_ready;
                w_ctrl.pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  w_ctrl.adr_src = 1'b1;
            S_MEMWB: begin
                w_ctrl.result_src = RES_MEM;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                w_ctrl.adr_src    = 1'b1;
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.instr_done = bus.mem_ready;
            end
            S_EXECR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_write   = 1'b1;
            end
            S_JALR: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.result_src = RES_ALU;
                w_ctrl.pc_write   = 1'b1;
            end
            S_JALRWB: begin
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALU;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_RS2;
                w_ctrl.alu_op     = ALUOP_BRANCH;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.instr_done = branch_legal(bus.funct3);
                w_ctrl.pc_write   = branch_taken(bus.funct3, bus.zero, bus.res31);
            end
            S_LUI: begin
                w_ctrl.alu_src_a = SRCA_ZERO;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_AUIPC: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_TRAP:     w_ctrl.illegal = 1'b1;
            default:    w_ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .opb5        (bus.op[5]),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_op      (w_ctrl.alu_op),
        .alu_control (bus.ALUControl)
    );

    // Enables and the done pulse are forced low for as long as reset is held.
    assign bus.PCWrite    = w_ctrl.pc_write   & ~reset;
    assign bus.IRWrite    = w_ctrl.ir_write   & ~reset;
    assign bus.MemWrite   = w_ctrl.mem_write  & ~reset;
    assign bus.RegWrite   = w_ctrl.reg_write  & ~reset;
    assign bus.instr_done = w_ctrl.instr_done & ~reset;
    assign bus.illegal    = w_ctrl.illegal;
    assign bus.AdrSrc     = w_ctrl.adr_src;
    assign bus.ResultSrc  = w_ctrl.result_src;
    assign bus.ALUSrcA    = w_ctrl.alu_src_a;
    assign bus.ALUSrcB    = w_ctrl.alu_src_b;
    assign bus.ImmSrc     = imm_src_of(bus.op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each cycle compares the whole
// output word against a hand-written expected vector.
module tb_multicycle_controller;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_SLT  = 4'd5;
    localparam logic [3:0] A_SLTU = 4'd6;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output word: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB
    //              ImmSrc ALUControl RegWrite instr_done illegal
    function automatic logic [19:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic rw, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, imm, alu, rw, done, ill};
    endfunction

    function automatic logic [19:0] observed();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                bus.RegWrite, bus.instr_done, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Compare outputs mid-cycle, then advance to the next falling edge.
    task automatic step(input string tag, input logic [19:0] exp);
        #1;
        check(tag, observed(), exp);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
    endtask

    // Common fetch (ready) and decode cycles for a given ImmSrc.
    task automatic fetch_decode(input string tag, input logic [2:0] imm);
        bus.mem_ready = 1'b1;
        step({tag, "_fetch"},  mk(1,0,0,1,2'b10,2'b00,2'b10,imm,A_ADD,0,0,0));
        step({tag, "_decode"}, mk(0,0,0,0,2'b00,2'b01,2'b01,imm,A_ADD,0,0,0));
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        bus.res31 = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        step("rst_idle", mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0,0));
        bus.mem_ready = 1'b1;
        step("rst_gate", mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0,0));
        reset = 1'b0;

        // add: 4 cycles
        fetch_decode("add", 3'b000);
        step("add_execr", mk(0,0,0,0,2'b00,2'b10,2'b00,3'b000,A_ADD,0,0,0));
        step("add_aluwb", mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,A_ADD,1,1,0));

        // sub through the funct path
        set_instr(7'b0110011, 3'b000, 1'b1);
        fetch_decode("sub", 3'b000);
        step("sub_execr", mk(0,0,0,0,2'b00,2'b10,2'b00,3'b000,A_SUB,0,0,0));
        step("sub_aluwb", mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,A_ADD,1,1,0));

        // lw with 3 stall cycles in MEMREAD: 8 cycles
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_decode("lw", 3'b000);
        step("lw_memadr", mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,A_ADD,0,0,0));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("lw_stall", mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,A_ADD,0,0,0));
        bus.mem_ready = 1'b1;
        step("lw_memread", mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,A_ADD,0,0,0));
        step("lw_memwb",   mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,A_ADD,1,1,0));

        // sw, ready on second MEMWRITE cycle
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode("sw", 3'b001);
        step("sw_memadr", mk(0,0,0,0,2'b00,2'b10,2'b01,3'b001,A_ADD,0,0,0));
        bus.mem_ready = 1'b0;
        step("sw_wait",   mk(0,1,1,0,2'b00,2'b00,2'b00,3'b001,A_ADD,0,0,0));
        bus.mem_ready = 1'b1;
        step("sw_done",   mk(0,1,1,0,2'b00,2'b00,2'b00,3'b001,A_ADD,0,1,0));

        // blt taken on res31
        set_instr(7'b1100011, 3'b100, 1'b0);
        fetch_decode("blt", 3'b010);
        bus.res31 = 1'b1; bus.zero = 1'b0;
        step("blt_taken", mk(1,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SLT,0,1,0));

        // bge taken on res31=0
        set_instr(7'b1100011, 3'b101, 1'b0);
        fetch_decode("bge", 3'b010);
        bus.res31 = 1'b0; bus.zero = 1'b0;
        step("bge_taken", mk(1,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SLT,0,1,0));

        // bne not taken when zero
        set_instr(7'b1100011, 3'b001, 1'b0);
        fetch_decode("bne", 3'b010);
        bus.zero = 1'b1;
        step("bne_not", mk(0,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SUB,0,1,0));

        // bgeu not taken: res31=1, zero=0
        set_instr(7'b1100011, 3'b111, 1'b0);
        fetch_decode("bgeu", 3'b010);
        bus.res31 = 1'b1; bus.zero = 1'b0;
        step("bgeu_not", mk(0,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SLTU,0,1,0));
        bus.res31 = 1'b0;

        // jal -> ALUWB
        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_decode("jal", 3'b011);
        step("jal_jal",   mk(1,0,0,0,2'b00,2'b01,2'b10,3'b011,A_ADD,0,0,0));
        step("jal_aluwb", mk(0,0,0,0,2'b00,2'b00,2'b00,3'b011,A_ADD,1,1,0));

        // lui -> ALUWB
        set_instr(7'b0110111, 3'b000, 1'b0);
        fetch_decode("lui", 3'b100);
        step("lui_lui",   mk(0,0,0,0,2'b00,2'b11,2'b01,3'b100,A_ADD,0,0,0));
        step("lui_aluwb", mk(0,0,0,0,2'b00,2'b00,2'b00,3'b100,A_ADD,1,1,0));

        // jalr then illegal opcode
        set_instr(7'b1100111, 3'b000, 1'b0);
        fetch_decode("jalr", 3'b000);
        step("jalr_jalr", mk(1,0,0,0,2'b10,2'b10,2'b01,3'b000,A_ADD,0,0,0));
        step("jalr_wb",   mk(0,0,0,0,2'b10,2'b01,2'b10,3'b000,A_ADD,1,1,0));
        set_instr(7'b0000000, 3'b000, 1'b0);
        fetch_decode("ill", 3'b000);
        for (int i = 0; i < 3; i++)
            step("trap_hold", mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,A_ADD,0,0,1));
        reset = 1'b1;
        step("trap_rst", mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0,0));
        reset = 1'b0;

        // reset during a stalled MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_decode("lw2", 3'b000);
        step("lw2_memadr", mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,A_ADD,0,0,0));
        bus.mem_ready = 1'b0;
        step("lw2_stall",  mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,A_ADD,0,0,0));
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        step("mid_rst",    mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0,0));
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        step("post_wait",  mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0,0));
        bus.mem_ready = 1'b1;
        step("post_fetch", mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0,0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
